// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - op codes, FSM state encoding and op-decode helpers for mem_stage_ls
package mem_pkg;

    localparam int MEM_OP_W = 4;

    // Memory op codes; 9..15 are unused and behave like OP_NONE.
    localparam logic [MEM_OP_W-1:0] OP_NONE = 4'd0,
                                    OP_LB   = 4'd1,
                                    OP_LBU  = 4'd2,
                                    OP_LH   = 4'd3,
                                    OP_LHU  = 4'd4,
                                    OP_LW   = 4'd5,
                                    OP_SB   = 4'd6,
                                    OP_SH   = 4'd7,
                                    OP_SW   = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_t;

    function automatic logic is_load(input logic [MEM_OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_signed_load(input logic [MEM_OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic size_t op_size(input logic [MEM_OP_W-1:0] op);
        size_t sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            OP_LW, OP_SW:         sz = SZ_WORD;
            default:              sz = SZ_NONE;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - combinational byte-lane formatter: byte enables, store replication, load extension
//
// Ports:
//   op_i         memory op code
//   addr_lo_i    low two bits of the effective byte address
//   wdata_i      raw store data (rt)
//   rdata_i      raw word read from data memory
//   be_o         byte enables for the access
//   wdata_o      lane-replicated store data
//   rdata_o      selected and sign/zero-extended load result
//   misaligned_o access violates its natural alignment
module mem_lane_fmt
    import mem_pkg::*;
#(
    parameter int BIG_ENDIAN = 0
) (
    input  logic [MEM_OP_W-1:0] op_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [31:0]         wdata_i,
    input  logic [31:0]         rdata_i,
    output logic [3:0]          be_o,
    output logic [31:0]         wdata_o,
    output logic [31:0]         rdata_o,
    output logic                misaligned_o
);

    // In big-endian mode lane = 3 - addr[1:0], which for two bits is addr ^ 2'b11.
    localparam logic [1:0] LANE_FLIP = (BIG_ENDIAN != 0) ? 2'b11 : 2'b00;

    size_t      size;
    logic [1:0] byte_lane;
    logic [1:0] half_lane;
    logic [7:0] rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        size      = op_size(op_i);
        byte_lane = addr_lo_i ^ LANE_FLIP;
        // Lowest lane of an aligned halfword is 0 or 2; big-endian swaps which
        // pair addr[1] selects.
        half_lane = {addr_lo_i[1] ^ LANE_FLIP[1], 1'b0};
        rd_byte   = rdata_i[{byte_lane, 3'b000} +: 8];
        rd_half   = rdata_i[{half_lane, 3'b000} +: 16];

        be_o         = 4'b0000;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
        misaligned_o = 1'b0;

        case (size)
            SZ_BYTE: begin
                be_o    = 4'b0001 << byte_lane;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = is_signed_load(op_i) ? {{24{rd_byte[7]}}, rd_byte}
                                               : {24'h0, rd_byte};
            end
            SZ_HALF: begin
                be_o         = 4'b0011 << half_lane;
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = is_signed_load(op_i) ? {{16{rd_half[15]}}, rd_half}
                                                    : {16'h0, rd_half};
                misaligned_o = addr_lo_i[0];
            end
            SZ_WORD: begin
                be_o         = 4'b1111;
                misaligned_o = |addr_lo_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_ls.sv
// rtl/mem_stage_ls.sv - MEM pipeline stage with registered MEM/WB output and data-memory load/store engine
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid / in_ready              EX/MEM entry handshake (ready only in IDLE)
//   mem_op_in, mem_addr_in,
//   mem_wdata_in                     memory op, byte address, store data
//   w_reg_*_in, hi_in, lo_in,
//   hilo_wen_in                      GPR and HI/LO write-back fields of the entry
//   dmem_req/we/addr/be/wdata        data-memory request, held stable while dmem_req
//   dmem_ack, dmem_rdata             request completion and read word
//   stall_req                        high while an access is outstanding
//   out_valid, w_reg_*_out, hi_out,
//   lo_out, hilo_wen_out             registered MEM/WB entry, one-cycle pulse
//   exc_adel, exc_ades, exc_badvaddr address-error flags and faulting address
module mem_stage_ls
    import mem_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 32,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MEM_OP_W-1:0]   mem_op_in,
    input  logic [MEM_ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0]     mem_wdata_in,
    input  logic [REG_ADDR_W-1:0] w_reg_addr_in,
    input  logic [DATA_W-1:0]     w_reg_data_in,
    input  logic                  w_reg_en_in,
    input  logic [DATA_W-1:0]     hi_in,
    input  logic [DATA_W-1:0]     lo_in,
    input  logic                  hilo_wen_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [MEM_ADDR_W-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  stall_req,
    output logic                  out_valid,
    output logic [REG_ADDR_W-1:0] w_reg_addr_out,
    output logic [DATA_W-1:0]     w_reg_data_out,
    output logic                  w_reg_en_out,
    output logic [DATA_W-1:0]     hi_out,
    output logic [DATA_W-1:0]     lo_out,
    output logic                  hilo_wen_out,
    output logic                  exc_adel,
    output logic                  exc_ades,
    output logic [MEM_ADDR_W-1:0] exc_badvaddr
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("mem_stage_ls: DATA_W must be 32");
    end

    state_t                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic                  wb_en_q, wb_en_d;
    logic [DATA_W-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                  hilo_wen_q, hilo_wen_d;
    logic                  adel_q, adel_d, ades_q, ades_d;
    logic [MEM_ADDR_W-1:0] badvaddr_q, badvaddr_d;
    logic                  req_q, req_d, we_q, we_d;
    logic [MEM_ADDR_W-1:0] daddr_q, daddr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_W-1:0]     dwdata_q, dwdata_d;

    // Entry parked while its memory access is outstanding.
    logic [MEM_OP_W-1:0]   ent_op_q, ent_op_d;
    logic [1:0]            ent_alo_q, ent_alo_d;
    logic [REG_ADDR_W-1:0] ent_waddr_q, ent_waddr_d;
    logic [DATA_W-1:0]     ent_wdata_q, ent_wdata_d;
    logic                  ent_wen_q, ent_wen_d;
    logic [DATA_W-1:0]     ent_hi_q, ent_hi_d, ent_lo_q, ent_lo_d;
    logic                  ent_hwen_q, ent_hwen_d;

    logic [MEM_OP_W-1:0]   fmt_op;
    logic [1:0]            fmt_alo;
    logic [3:0]            fmt_be;
    logic [DATA_W-1:0]     fmt_wdata, fmt_rdata;
    logic                  fmt_misaligned;
    logic                  op_is_mem;

    // One formatter serves both phases: the incoming op while IDLE (enables,
    // store data, alignment) and the parked op while WAIT (load extension).
    assign fmt_op    = (state_q == ST_IDLE) ? mem_op_in : ent_op_q;
    assign fmt_alo   = (state_q == ST_IDLE) ? mem_addr_in[1:0] : ent_alo_q;
    assign op_is_mem = is_load(mem_op_in) || is_store(mem_op_in);

    mem_lane_fmt #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_fmt (
        .op_i         (fmt_op),
        .addr_lo_i    (fmt_alo),
        .wdata_i      (mem_wdata_in),
        .rdata_i      (dmem_rdata),
        .be_o         (fmt_be),
        .wdata_o      (fmt_wdata),
        .rdata_o      (fmt_rdata),
        .misaligned_o (fmt_misaligned)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        wb_addr_d   = '0;
        wb_data_d   = '0;
        wb_en_d     = 1'b0;
        hi_d        = '0;
        lo_d        = '0;
        hilo_wen_d  = 1'b0;
        adel_d      = 1'b0;
        ades_d      = 1'b0;
        badvaddr_d  = '0;
        req_d       = req_q;
        we_d        = we_q;
        daddr_d     = daddr_q;
        be_d        = be_q;
        dwdata_d    = dwdata_q;
        ent_op_d    = ent_op_q;
        ent_alo_d   = ent_alo_q;
        ent_waddr_d = ent_waddr_q;
        ent_wdata_d = ent_wdata_q;
        ent_wen_d   = ent_wen_q;
        ent_hi_d    = ent_hi_q;
        ent_lo_d    = ent_lo_q;
        ent_hwen_d  = ent_hwen_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (op_is_mem && fmt_misaligned) begin
                        // Address error: no bus access and write-backs suppressed.
                        out_valid_d = 1'b1;
                        wb_addr_d   = w_reg_addr_in;
                        wb_data_d   = w_reg_data_in;
                        hi_d        = hi_in;
                        lo_d        = lo_in;
                        adel_d      = is_load(mem_op_in);
                        ades_d      = is_store(mem_op_in);
                        badvaddr_d  = mem_addr_in;
                    end else if (op_is_mem) begin
                        state_d     = ST_WAIT;
                        req_d       = 1'b1;
                        we_d        = is_store(mem_op_in);
                        daddr_d     = {mem_addr_in[MEM_ADDR_W-1:2], 2'b00};
                        be_d        = fmt_be;
                        dwdata_d    = fmt_wdata;
                        ent_op_d    = mem_op_in;
                        ent_alo_d   = mem_addr_in[1:0];
                        ent_waddr_d = w_reg_addr_in;
                        ent_wdata_d = w_reg_data_in;
                        ent_wen_d   = w_reg_en_in;
                        ent_hi_d    = hi_in;
                        ent_lo_d    = lo_in;
                        ent_hwen_d  = hilo_wen_in;
                    end else begin
                        out_valid_d = 1'b1;
                        wb_addr_d   = w_reg_addr_in;
                        wb_data_d   = w_reg_data_in;
                        wb_en_d     = w_reg_en_in;
                        hi_d        = hi_in;
                        lo_d        = lo_in;
                        hilo_wen_d  = hilo_wen_in;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_d     = ST_IDLE;
                    req_d       = 1'b0;
                    out_valid_d = 1'b1;
                    wb_addr_d   = ent_waddr_q;
                    wb_data_d   = is_load(ent_op_q) ? fmt_rdata : ent_wdata_q;
                    wb_en_d     = ent_wen_q;
                    hi_d        = ent_hi_q;
                    lo_d        = ent_lo_q;
                    hilo_wen_d  = ent_hwen_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            wb_en_q     <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            hilo_wen_q  <= 1'b0;
            adel_q      <= 1'b0;
            ades_q      <= 1'b0;
            badvaddr_q  <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            daddr_q     <= '0;
            be_q        <= '0;
            dwdata_q    <= '0;
            ent_op_q    <= OP_NONE;
            ent_alo_q   <= '0;
            ent_waddr_q <= '0;
            ent_wdata_q <= '0;
            ent_wen_q   <= 1'b0;
            ent_hi_q    <= '0;
            ent_lo_q    <= '0;
            ent_hwen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_en_q     <= wb_en_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            hilo_wen_q  <= hilo_wen_d;
            adel_q      <= adel_d;
            ades_q      <= ades_d;
            badvaddr_q  <= badvaddr_d;
            req_q       <= req_d;
            we_q        <= we_d;
            daddr_q     <= daddr_d;
            be_q        <= be_d;
            dwdata_q    <= dwdata_d;
            ent_op_q    <= ent_op_d;
            ent_alo_q   <= ent_alo_d;
            ent_waddr_q <= ent_waddr_d;
            ent_wdata_q <= ent_wdata_d;
            ent_wen_q   <= ent_wen_d;
            ent_hi_q    <= ent_hi_d;
            ent_lo_q    <= ent_lo_d;
            ent_hwen_q  <= ent_hwen_d;
        end
    end

    assign in_ready       = (state_q == ST_IDLE);
    assign stall_req      = (state_q == ST_WAIT);
    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = daddr_q;
    assign dmem_be        = be_q;
    assign dmem_wdata     = dwdata_q;
    assign out_valid      = out_valid_q;
    assign w_reg_addr_out = wb_addr_q;
    assign w_reg_data_out = wb_data_q;
    assign w_reg_en_out   = wb_en_q;
    assign hi_out         = hi_q;
    assign lo_out         = lo_q;
    assign hilo_wen_out   = hilo_wen_q;
    assign exc_adel       = adel_q;
    assign exc_ades       = ades_q;
    assign exc_badvaddr   = badvaddr_q;

endmodule

// File: tb/tb_mem_stage_ls.sv
// tb/tb_mem_stage_ls.sv - self-checking bench for mem_stage_ls (little- and big-endian instances side by side)
module tb_mem_stage_ls;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  mem_op_in = 4'd0;
    logic [31:0] mem_addr_in = 32'd0;
    logic [31:0] mem_wdata_in = 32'd0;
    logic [4:0]  w_reg_addr_in = 5'd0;
    logic [31:0] w_reg_data_in = 32'd0;
    logic        w_reg_en_in = 1'b0;
    logic [31:0] hi_in = 32'd0;
    logic [31:0] lo_in = 32'd0;
    logic        hilo_wen_in = 1'b0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;

    // Index 0: little-endian instance, index 1: big-endian instance.
    logic        rdy[2], req[2], we[2], stall[2], ov[2], wen[2], hwen[2], adel[2], ades[2];
    logic [31:0] daddr[2], dwd[2], wdo[2], hio[2], loo[2], badv[2];
    logic [3:0]  be[2];
    logic [4:0]  wao[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_stage_ls #(
            .REG_ADDR_W (5),
            .DATA_W     (32),
            .MEM_ADDR_W (32),
            .BIG_ENDIAN (g)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .in_valid       (in_valid),
            .in_ready       (rdy[g]),
            .mem_op_in      (mem_op_in),
            .mem_addr_in    (mem_addr_in),
            .mem_wdata_in   (mem_wdata_in),
            .w_reg_addr_in  (w_reg_addr_in),
            .w_reg_data_in  (w_reg_data_in),
            .w_reg_en_in    (w_reg_en_in),
            .hi_in          (hi_in),
            .lo_in          (lo_in),
            .hilo_wen_in    (hilo_wen_in),
            .dmem_req       (req[g]),
            .dmem_we        (we[g]),
            .dmem_addr      (daddr[g]),
            .dmem_be        (be[g]),
            .dmem_wdata     (dwd[g]),
            .dmem_ack       (dmem_ack),
            .dmem_rdata     (dmem_rdata),
            .stall_req      (stall[g]),
            .out_valid      (ov[g]),
            .w_reg_addr_out (wao[g]),
            .w_reg_data_out (wdo[g]),
            .w_reg_en_out   (wen[g]),
            .hi_out         (hio[g]),
            .lo_out         (loo[g]),
            .hilo_wen_out   (hwen[g]),
            .exc_adel       (adel[g]),
            .exc_ades       (ades[g]),
            .exc_badvaddr   (badv[g])
        );
    end

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (memory-byte view) ----------------
    function automatic int m_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    // Byte of the word at byte offset k within the word, for the given endianness.
    function automatic logic [7:0] m_byte(input logic [31:0] w, input int k, input bit bige);
        int lane;
        lane = bige ? 3 - k : k;
        return w[8*lane +: 8];
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata, input bit bige);
        int n, o;
        logic [31:0] v;
        n = m_size(op);
        o = int'(addr[1:0]);
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (bige) v = (v << 8) | {24'h0, m_byte(rdata, o + i, bige)};
            else      v = v | ({24'h0, m_byte(rdata, o + i, bige)} << (8 * i));
        end
        if (op == 4'd1) v = {{24{v[7]}}, v[7:0]};
        if (op == 4'd3) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] addr, input bit bige);
        logic [3:0] b;
        int o, k;
        b = 4'b0000;
        o = int'(addr[1:0]);
        for (int i = 0; i < m_size(op); i++) begin
            k = o + i;
            b[bige ? 3 - k : k] = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] w);
        if (m_size(op) == 1) return {4{w[7:0]}};
        if (m_size(op) == 2) return {2{w[15:0]}};
        return w;
    endfunction

    typedef struct {
        int          due;
        logic        exc, adel, ades;
        logic [31:0] badv;
        logic [4:0]  wa;
        logic [31:0] wd_le, wd_be;
        logic        wen;
        logic [31:0] hi, lo;
        logic        hwen;
    } exp_t;

    exp_t q[$];

    // Expectations for the cycle following the next clock edge.
    logic        exp_zero = 1'b1;
    logic        exp_req  = 1'b0;
    logic        exp_we   = 1'b0;
    logic [31:0] exp_addr = 32'd0;
    logic [3:0]  exp_be[2];
    logic [31:0] exp_dwd  = 32'd0;

    // ---------------- compare process ----------------
    initial begin : compare
        exp_t e;
        logic v;
        forever begin
            @(posedge clk);
            #1;
            v = (q.size() > 0) && (q[0].due == cyc);
            if (v) e = q.pop_front();
            for (int d = 0; d < 2; d++) begin
                if (exp_zero) begin
                    chk($sformatf("d%0d reset out_valid", d), 32'(ov[d]), 32'd0);
                    chk($sformatf("d%0d reset dmem_req", d), 32'(req[d]), 32'd0);
                    chk($sformatf("d%0d reset dmem_we/be", d), {27'd0, we[d], be[d]}, 32'd0);
                    chk($sformatf("d%0d reset dmem_addr", d), daddr[d], 32'd0);
                    chk($sformatf("d%0d reset dmem_wdata", d), dwd[d], 32'd0);
                    chk($sformatf("d%0d reset wb addr/en", d), {25'd0, wao[d], wen[d], hwen[d]}, 32'd0);
                    chk($sformatf("d%0d reset wb data", d), wdo[d], 32'd0);
                    chk($sformatf("d%0d reset hi|lo", d), hio[d] | loo[d], 32'd0);
                    chk($sformatf("d%0d reset exc", d), {29'd0, adel[d], ades[d], |badv[d]}, 32'd0);
                    chk($sformatf("d%0d reset in_ready", d), 32'(rdy[d]), 32'd1);
                end else begin
                    chk($sformatf("d%0d out_valid", d), 32'(ov[d]), 32'(v));
                    if (v && !e.exc) begin
                        chk($sformatf("d%0d wb addr", d), 32'(wao[d]), 32'(e.wa));
                        chk($sformatf("d%0d wb data", d), wdo[d], d == 0 ? e.wd_le : e.wd_be);
                        chk($sformatf("d%0d wb en", d), 32'(wen[d]), 32'(e.wen));
                        chk($sformatf("d%0d hi", d), hio[d], e.hi);
                        chk($sformatf("d%0d lo", d), loo[d], e.lo);
                        chk($sformatf("d%0d hilo en", d), 32'(hwen[d]), 32'(e.hwen));
                        chk($sformatf("d%0d exc flags", d), {30'd0, adel[d], ades[d]}, 32'd0);
                    end else if (v) begin
                        chk($sformatf("d%0d exc adel/ades", d), {30'd0, adel[d], ades[d]},
                            {30'd0, e.adel, e.ades});
                        chk($sformatf("d%0d exc badvaddr", d), badv[d], e.badv);
                        chk($sformatf("d%0d exc wb enables", d), {30'd0, wen[d], hwen[d]}, 32'd0);
                    end else begin
                        chk($sformatf("d%0d bubble enables", d),
                            {28'd0, wen[d], hwen[d], adel[d], ades[d]}, 32'd0);
                    end
                    chk($sformatf("d%0d dmem_req", d), 32'(req[d]), 32'(exp_req));
                    chk($sformatf("d%0d in_ready", d), 32'(rdy[d]), 32'(!exp_req));
                    chk($sformatf("d%0d stall_req", d), 32'(stall[d]), 32'(exp_req));
                    if (exp_req) begin
                        chk($sformatf("d%0d dmem_addr", d), daddr[d], exp_addr);
                        chk($sformatf("d%0d dmem_we", d), 32'(we[d]), 32'(exp_we));
                        chk($sformatf("d%0d dmem_be", d), 32'(be[d]), 32'(exp_be[d]));
                        if (exp_we) chk($sformatf("d%0d dmem_wdata", d), dwd[d], exp_dwd);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- driver ----------------
    logic [3:0]  cap_be[2];
    logic [31:0] cap_wd, cap_addr;
    logic        cap_we;
    int          req_cnt;

    task automatic set_exp_dmem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        exp_req   = 1'b1;
        exp_we    = (op >= 4'd6) && (op <= 4'd8);
        exp_addr  = {addr[31:2], 2'b00};
        exp_be[0] = m_be(op, addr, 1'b0);
        exp_be[1] = m_be(op, addr, 1'b1);
        exp_dwd   = m_wdata(op, wdata);
    endtask

    // Called at a falling edge; returns at the falling edge where the result is visible.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int lat, input logic [4:0] wa,
                          input logic [31:0] wd, input logic wen_i, input logic [31:0] hi,
                          input logic [31:0] lo, input logic hwen_i);
        exp_t e;
        logic ld, st, mis;
        int   n;
        n   = m_size(op);
        ld  = (op >= 4'd1) && (op <= 4'd5);
        st  = (op >= 4'd6) && (op <= 4'd8);
        mis = ((n == 2) && addr[0]) || ((n == 4) && (addr[1:0] != 2'b00));
        e.due   = 0;
        e.exc   = (ld || st) && mis;
        e.adel  = ld && mis;
        e.ades  = st && mis;
        e.badv  = addr;
        e.wa    = wa;
        e.wd_le = ld ? m_load(op, addr, rdata, 1'b0) : wd;
        e.wd_be = ld ? m_load(op, addr, rdata, 1'b1) : wd;
        e.wen   = e.exc ? 1'b0 : wen_i;
        e.hi    = hi;
        e.lo    = lo;
        e.hwen  = e.exc ? 1'b0 : hwen_i;

        in_valid = 1'b1; mem_op_in = op; mem_addr_in = addr; mem_wdata_in = wdata;
        w_reg_addr_in = wa; w_reg_data_in = wd; w_reg_en_in = wen_i;
        hi_in = hi; lo_in = lo; hilo_wen_in = hwen_i;

        if ((ld || st) && !mis) begin
            set_exp_dmem(op, addr, wdata);
            @(negedge clk);
            cap_be[0] = be[0]; cap_be[1] = be[1];
            cap_wd = dwd[0]; cap_addr = daddr[0]; cap_we = we[0];
            // A competing entry offered during WAIT must not be taken.
            mem_op_in = 4'd0; w_reg_addr_in = 5'h1f; w_reg_data_in = 32'hBAD0_0000;
            req_cnt = 0;
            for (int i = 0; i < lat; i++) begin
                if (i > 0) @(negedge clk);
                req_cnt += int'(req[0]);
            end
            in_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = rdata; exp_req = 1'b0;
            e.due = cyc + 1;
            q.push_back(e);
            @(negedge clk);
            req_cnt += int'(req[0]);
            dmem_ack = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
        end else begin
            e.due = cyc + 1;
            q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin : driver
        exp_be[0] = 4'd0; exp_be[1] = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; exp_zero = 1'b0;
        @(negedge clk);

        // Pass-through of NONE; no bus activity.
        run_op(4'd0, 32'h0, 32'h0, 32'h0, 0, 5'd5, 32'hDEADBEEF, 1'b1, 32'd1, 32'd2, 1'b1);
        chk("lit none data", wdo[0], 32'hDEADBEEF);
        chk("lit none addr/hi/lo", {wao[0], hio[0][7:0], loo[0][7:0]}, {5'd5, 8'd1, 8'd2});
        // Unused op code 12 behaves like NONE.
        run_op(4'd12, 32'h1234, 32'h0, 32'h0, 0, 5'd9, 32'h0BAD_F00D, 1'b1, 32'hAA, 32'hBB, 1'b0);

        // LB at 0x1003, three request cycles.
        run_op(4'd1, 32'h1003, 32'h0, 32'h80FF7F01, 3, 5'd8, 32'h0, 1'b1, 32'h11, 32'h22, 1'b1);
        chk("lit lb be", 32'(cap_be[0]), 32'h8);
        chk("lit lb req cycles", 32'(req_cnt), 32'd3);
        chk("lit lb result", wdo[0], 32'hFFFFFF80);

        // Big-endian halfword loads.
        run_op(4'd4, 32'h2002, 32'h0, 32'h1234ABCD, 2, 5'd3, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
        chk("lit lhu be(BE)", 32'(cap_be[1]), 32'h3);
        chk("lit lhu result(BE)", wdo[1], 32'h0000ABCD);
        run_op(4'd3, 32'h2000, 32'h0, 32'h80010000, 1, 5'd4, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
        chk("lit lh result(BE)", wdo[1], 32'hFFFF8001);

        // SH store.
        run_op(4'd7, 32'h3002, 32'h0000BEEF, 32'h0, 2, 5'd6, 32'h77, 1'b0, 32'h5, 32'h6, 1'b1);
        chk("lit sh we", 32'(cap_we), 32'd1);
        chk("lit sh be", 32'(cap_be[0]), 32'hC);
        chk("lit sh wdata", cap_wd, 32'hBEEFBEEF);
        chk("lit sh addr", cap_addr, 32'h3000);

        // Address errors.
        run_op(4'd5, 32'h4001, 32'h0, 32'h0, 1, 5'd7, 32'h1, 1'b1, 32'h0, 32'h0, 1'b1);
        chk("lit lw adel", {30'd0, adel[0], wen[0]}, 32'h2);
        chk("lit lw badvaddr", badv[0], 32'h4001);
        run_op(4'd8, 32'h4002, 32'h1, 32'h0, 1, 5'd7, 32'h1, 1'b1, 32'h0, 32'h0, 1'b1);
        chk("lit sw ades", 32'(ades[0]), 32'd1);
        run_op(4'd4, 32'h7001, 32'h0, 32'h0, 1, 5'd2, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);

        // More lanes.
        run_op(4'd2, 32'h5001, 32'h0, 32'h00C3A500, 1, 5'd10, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
        run_op(4'd6, 32'h6001, 32'h12345678, 32'h0, 4, 5'd11, 32'h99, 1'b1, 32'h3, 32'h4, 1'b1);
        run_op(4'd5, 32'h8000, 32'h0, 32'hCAFEF00D, 2, 5'd12, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1);
        run_op(4'd1, 32'h8002, 32'h0, 32'h00FF7F00, 1, 5'd13, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);

        // Reset in the middle of WAIT abandons the access.
        in_valid = 1'b1; mem_op_in = 4'd5; mem_addr_in = 32'h9000; w_reg_en_in = 1'b1;
        set_exp_dmem(4'd5, 32'h9000, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0; exp_req = 1'b0; exp_zero = 1'b1;
        @(negedge clk);
        chk("lit reset drops req", 32'(req[0]), 32'd0);
        rst_n = 1'b1; exp_zero = 1'b0;
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        @(negedge clk);
        run_op(4'd0, 32'h0, 32'h0, 32'h0, 0, 5'd1, 32'h600D_0001, 1'b1, 32'h7, 32'h8, 1'b0);
        chk("lit after reset none", wdo[0], 32'h600D_0001);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errs++;
            checks++;
            $display("FAIL pending results: got %0d expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_ls.md
Name: mem_stage_ls

Overview:
- Parametrised successor of the MIPS MEM pass-through stage.
- Adds a registered MEM/WB output and a data-memory load/store engine with a req/ack handshake.
- Adds sub-word load/store with sign/zero extension, configurable endianness and address-error detection.
- Sits between EX/MEM and WB; forwards GPR and HI/LO write-backs and stalls the pipe while a memory access is outstanding.

Parameters:
- REG_ADDR_W, 5: GPR index width.
- DATA_W, 32: register/data width; only 32 is supported, and elaboration fails otherwise.
- MEM_ADDR_W, 32: data-memory byte-address width.
- BIG_ENDIAN, 0: 0 = little-endian byte lanes, 1 = big-endian.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  EX/MEM entry valid
- in_ready  out  1  stage can accept; equals (state==IDLE)
- mem_op_in  in  4  memory op code (pkg encoding)
- mem_addr_in  in  MEM_ADDR_W  effective byte address
- mem_wdata_in  in  DATA_W  store data (rt)
- w_reg_addr_in  in  REG_ADDR_W  GPR destination
- w_reg_data_in  in  DATA_W  ALU result
- w_reg_en_in  in  1  GPR write enable
- hi_in, lo_in  in  DATA_W  HI/LO values
- hilo_wen_in  in  1  HI/LO write enable
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  MEM_ADDR_W  word-aligned address (low 2 bits 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  DATA_W  lane-replicated store data
- dmem_ack  in  1  request complete (rdata valid for loads)
- dmem_rdata  in  DATA_W  read word
- stall_req  out  1  to hazard unit; equals (state==WAIT)
- out_valid  out  1  WB entry valid
- w_reg_addr_out, w_reg_data_out, w_reg_en_out  out  REG_ADDR_W/DATA_W/1  GPR write-back
- hi_out, lo_out, hilo_wen_out  out  DATA_W/DATA_W/1  HI/LO write-back
- exc_adel, exc_ades  out  1  load/store address error
- exc_badvaddr  out  MEM_ADDR_W  faulting address

Behaviour:
- Reset rst_n: synchronous, active-low. State goes to IDLE. All outputs are 0: out_valid, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, w_reg_*_out, hi/lo/hilo_wen_out, exc_* and exc_badvaddr.
- Reset mid-WAIT abandons the access. dmem_req drops in the cycle after the reset edge, and no result is produced.
- Accept condition: in_valid & in_ready. All inputs are latched at accept.
- FSM states are IDLE and WAIT.
- IDLE, accept of NONE or any unused op code: out_valid=1 on the next cycle with all in_* passed through; stay IDLE.
- IDLE, accept of a misaligned op: no bus access. A halfword op is misaligned when addr[0]≠0; a word op when addr[1:0]≠0. Next cycle: out_valid=1, exc_adel (loads) or exc_ades (stores) =1, exc_badvaddr=addr, w_reg_en_out=0, hilo_wen_out=0. Stay IDLE.
- IDLE, accept of an aligned load/store: go to WAIT. dmem_req=1 from the next cycle. dmem_addr, dmem_we, dmem_be and dmem_wdata are registered and held stable while dmem_req=1.
- WAIT: hold the request until dmem_ack. In the ack cycle, capture dmem_rdata and go to IDLE. In the following cycle: out_valid=1 and dmem_req=0.
- Minimum memory-op latency is 2 cycles, accept to out_valid. in_ready=0 throughout WAIT.
- out_valid is a single-cycle pulse per accepted entry. Without an accept the stage outputs bubbles: out_valid=0 and all enables 0.
- Lane index: lane = addr[1:0] when BIG_ENDIAN=0, and 3−addr[1:0] when BIG_ENDIAN=1. A halfword occupies lanes {lane, lane+1} (LE) or {lane−1, lane} (BE), mapped to byte-enable bits.
- Byte enables: SB/LB/LBU use one bit. SH/LH/LHU use two bits. SW/LW use 4'b1111.
- Store data: SB replicates byte×4; SH replicates halfword×2; SW sends the word unchanged.
- Load result: the selected byte/halfword is sign-extended (LB, LH) or zero-extended (LBU, LHU). LW is the raw word.
- Load write-back: w_reg_data_out = load result, w_reg_en_out = latched w_reg_en_in.
- Stores forward the latched w_reg_* unchanged.
- HI/LO are forwarded unchanged with their entry on every non-exception op.
- dmem_ack while in IDLE is ignored.

Decomposition:
- Package mem_pkg holds MEM_OP_W=4 and the op codes: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8, with 9–15 treated as NONE.
- mem_pkg also holds the is_load/is_store/size helper functions and the state encoding.
- One sub-module, mem_lane_fmt, is purely combinational. It takes op, addr[1:0] and the endianness parameter. It produces be, replicated wdata, extended rdata and a misaligned flag.

Test Plan:
- Pass-through: NONE op, w_reg_addr=5, data=0xDEADBEEF, en=1, hilo_wen=1 with hi=1, lo=2 → next cycle out_valid=1 with identical values; dmem_req never asserts.
- LB at 0x1003, LE, ack after 3 WAIT cycles with rdata=0x80FF7F01 → be=4'b1000; dmem_req high for exactly 3 cycles; in_ready low; w_reg_data_out=0xFFFFFF80 one cycle after ack.
- LHU at 0x2002 with BIG_ENDIAN=1, rdata=0x1234ABCD → be=4'b0011, result=0x0000ABCD. Repeat LH at 0x2000 with rdata=0x8001_0000 → 0xFFFF8001.
- SH at 0x3002, LE, wdata=0x0000BEEF → dmem_we=1, be=4'b1100, dmem_wdata=0xBEEFBEEF, dmem_addr=0x3000.
- LW at 0x4001 → no dmem_req; next cycle exc_adel=1, exc_badvaddr=0x4001, w_reg_en_out=0. SW at 0x4002 → exc_ades=1.
- rst_n=0 during WAIT → dmem_req drops in the cycle after the reset edge, no out_valid, state IDLE. A later ack is ignored, and a new NONE op passes normally.
